div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle 32-bit integer divider controller for the MIPS DIV/DIVU instructions. It time-multiplexes a single 32-bit borrow-chain `Subtractor` over 32 restoring-division steps and applies sign correction for signed operation. Results go to the HI/LO registers: remainder to HI, quotient to LO. It handshakes with the pipeline stall logic through `start`, `busy` and `done`.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE or DONE.
- `is_signed` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `abort` input 1: synchronous cancel, e.g. on pipeline flush.
- `dividend` input 32: dividend, latched when `start` is accepted.
- `divisor` input 32: divisor, latched when `start` is accepted.
- `busy` output 1: high in CALC and SIGN.
- `done` output 1: one-cycle pulse; results are valid.
- `quotient` output 32: quotient, destined for LO.
- `remainder` output 32: remainder, destined for HI.
- `div_zero` output 1: set with `done` when the divisor was 0; held until the next accepted `start`.

## Operation
- States:
  - IDLE: `start` latches operands, goes to CALC, and clears the counter.
  - CALC: 32 cycles.
  - SIGN: 1 cycle.
  - DONE: 1 cycle, then IDLE.
  - DONE accepts `start` exactly like IDLE, allowing back-to-back operation.
  - On `start` with divisor == 0, go directly to DONE and skip CALC/SIGN.
- Operand latch:
  - If `is_signed`, store |dividend| and |divisor|. Negation is 0 − x, and the magnitude is taken as unsigned 32-bit.
  - Store `neg_q` = sign(dividend) ^ sign(divisor) and `neg_r` = sign(dividend).
- CALC step, with registers R (partial remainder) and Q (shifts the dividend out and the quotient in):
  - P = {R[30:0], Q[31]}.
  - D = P − divisor, computed on the `Subtractor` with bin = 0.
  - q_bit = R[31] | ~CF. R[31] = 1 means the 33-bit P exceeds any 32-bit divisor.
  - R ← q_bit ? D : P.
  - Q ← {Q[30:0], q_bit}.
  - The 5-bit counter increments each step; exit CALC when the counter reaches 31.
- SIGN state:
  - If `is_signed` && `neg_q`, negate Q.
  - If `is_signed` && `neg_r`, negate R.
  - Load `quotient`/`remainder` from Q/R.
- Divide by zero: `quotient` = 0xFFFFFFFF, `remainder` = dividend as supplied (no sign handling), `div_zero` = 1.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: no special case. The natural result is `quotient` = 0x80000000, `remainder` = 0.
- `start` while `busy`: ignored, with no effect on operands or state.
- `abort`: from any state, go to IDLE next edge.
  - `done` is not asserted.
  - `quotient`/`remainder`/`div_zero` keep their previous values.
  - `abort` takes priority over a simultaneous `start`.
- `is_signed`, `dividend` and `divisor` are don't-care except in the cycle where `start` is accepted.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `div_zero` = 0, `quotient` = 0, `remainder` = 0, internal R/Q/counter = 0.
- Reset mid-operation clears everything immediately, asynchronously; no `done` is produced.
- Nonzero divisor, with `start` accepted at edge E0:
  - CALC occupies edges E1..E32, with `busy` high from after E0.
  - SIGN is at E33.
  - DONE holds after E33; `done` is high for exactly one cycle, edges E33–E34.
  - Results are stable from E33 until the next DONE load.
  - Latency is 34 cycles, start edge to done-high cycle inclusive of the SIGN cycle.
- Zero divisor: `done` is high in the cycle after E0. `busy` never asserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `div_pkg`:
  - State encoding: DIV_IDLE, DIV_CALC, DIV_SIGN, DIV_DONE.
  - DIV_WIDTH = 32.
  - DIV_STEPS = 32.
  - DIV_ZERO_QUOT = 32'hFFFFFFFF.
- One sub-module instance: the existing `Subtractor` (X = P, Y = latched divisor, bin = 0). Only its `CF` and `Result` are used; `OF` is unconnected.
- Operand and result negation uses a plain 0 − x expression; it is not shared with the step subtractor.

## Test plan
- DIVU 100 / 7 → `done` 34 cycles after start, `quotient` = 14, `remainder` = 2, `div_zero` = 0.
- DIV −7 (0xFFFFFFF9) / 2 → `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF. Also DIV 7 / −2 → `quotient` = 0xFFFFFFFD, `remainder` = 1.
- DIVU 0xFFFFFFFF / 1 → `quotient` = 0xFFFFFFFF, `remainder` = 0. DIV 0x80000000 / 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0.
- DIVU 1234 / 0 → `done` the cycle after start, `busy` never high, `quotient` = 0xFFFFFFFF, `remainder` = 1234, `div_zero` = 1.
- 100 / 7 started, then:
  - `start` with 50 / 5 pulsed at cycle 10 → ignored; results 14 / 2.
  - A new `start` in the DONE cycle → accepted; next results 10 / 0.
- `abort` at cycle 15 of a division → IDLE, no `done`, outputs unchanged. `rst` asserted at cycle 20 of a second division → all outputs 0 immediately.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU sequencer.
// Imported by the sequencer top and the step subtractor.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_SIGN,
        DIV_DONE
    } div_state_t;

    // Two's complement negation, read back as an unsigned magnitude
    function automatic logic [DIV_WIDTH-1:0] div_neg(
        input logic [DIV_WIDTH-1:0] x
    );
        return {DIV_WIDTH{1'b0}} - x;
    endfunction

endpackage

// File: rtl/div_sequencer_subtractor.sv
// Borrow-chain subtractor: Result = X - Y - bin.
// CF is the borrow out, OF the signed overflow flag.
module Subtractor
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         bin,
    output logic [W-1:0] Result,
    output logic         CF,
    output logic         OF
);

    logic [W:0] full;

    // One wide subtract; the top bit of the extended result is the borrow
    always_comb begin
        full   = {1'b0, X} - {1'b0, Y} - {{W{1'b0}}, bin};
        Result = full[W-1:0];
        CF     = full[W];
        OF     = (X[W-1] ^ Y[W-1]) & (X[W-1] ^ full[W-1]);
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller for MIPS DIV/DIVU.
// Remainder goes to HI, quotient to LO; one subtractor reused per step.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t state;

    logic [DIV_WIDTH-1:0] r;
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] dvs;
    logic [4:0]           cnt;
    logic                 sgn;
    logic                 neg_q;
    logic                 neg_r;

    logic [DIV_WIDTH-1:0] p;
    logic [DIV_WIDTH-1:0] d;
    logic                 cf;
    logic                 q_bit;
    logic                 of_unused;

    // Shift the next dividend bit into the partial remainder
    always_comb begin
        p     = {r[DIV_WIDTH-2:0], q[DIV_WIDTH-1]};
        q_bit = r[DIV_WIDTH-1] | ~cf;
    end

    Subtractor #(
        .W (DIV_WIDTH)
    ) u_sub (
        .X      (p),
        .Y      (dvs),
        .bin    (1'b0),
        .Result (d),
        .CF     (cf),
        .OF     (of_unused)
    );

    // Controller FSM with datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DIV_IDLE;
            r         <= '0;
            q         <= '0;
            dvs       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (abort) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                DIV_IDLE, DIV_DONE: begin
                    done  <= 1'b0;
                    state <= DIV_IDLE;
                    if (start) begin
                        div_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient  <= DIV_ZERO_QUOT;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            state     <= DIV_DONE;
                        end else begin
                            r     <= '0;
                            q     <= (is_signed && dividend[DIV_WIDTH-1])
                                     ? div_neg(dividend) : dividend;
                            dvs   <= (is_signed && divisor[DIV_WIDTH-1])
                                     ? div_neg(divisor) : divisor;
                            sgn   <= is_signed;
                            neg_q <= dividend[DIV_WIDTH-1]
                                     ^ divisor[DIV_WIDTH-1];
                            neg_r <= dividend[DIV_WIDTH-1];
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r   <= q_bit ? d : p;
                    q   <= {q[DIV_WIDTH-2:0], q_bit};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_STEPS - 1))
                        state <= DIV_SIGN;
                end
                DIV_SIGN: begin
                    quotient  <= (sgn && neg_q) ? div_neg(q) : q;
                    remainder <= (sgn && neg_r) ? div_neg(r) : r;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DIV_DONE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer.
// Each task drives one scenario and checks against hand-computed values.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic        abort;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int vectors;
    int errors;

    div_sequencer #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .abort     (abort),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for one edge (E0); returns 1 time unit after E0
    task automatic pulse_start(
        input logic        sg,
        input logic [31:0] a,
        input logic [31:0] b
    );
        @(negedge clk);
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0;
        is_signed = 1'b0;
    endtask

    // Count edges after E0 until done is seen (bounded)
    task automatic wait_done(output int n, output bit ok);
        n  = 1;
        ok = 1'b0;
        if (done) begin
            ok = 1'b1;
        end else begin
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (done) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Run one nonzero-divisor division and check latency and results
    task automatic run_div(
        input string       name,
        input logic        sg,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] exp_q,
        input logic [31:0] exp_r
    );
        int n;
        bit ok;
        pulse_start(sg, a, b);
        n = 0;
        wait_done(n, ok);
        vectors++;
        if (!ok || n !== 34) begin
            errors++;
            $display("FAIL %s latency: got %0d (ok=%0d) want 34", name, n, ok);
        end
        vectors++;
        if (quotient !== exp_q || remainder !== exp_r || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s result: q=%h r=%h dz=%b want q=%h r=%h dz=0",
                     name, quotient, remainder, div_zero, exp_q, exp_r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, div_zero} !== 3'b000 || quotient !== 32'h0
            || remainder !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
    endtask

    task automatic test_divu;
        int n;
        bit ok;
        pulse_start(1'b0, 32'd100, 32'd7);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL divu busy after E0: got %b want 1", busy);
        end
        n = 0;
        wait_done(n, ok);
        vectors++;
        if (!ok || n !== 34) begin
            errors++;
            $display("FAIL divu latency: got %0d want 34", n);
        end
        vectors++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL divu 100/7: q=%0d r=%0d dz=%b busy=%b want 14 2 0 0",
                     quotient, remainder, div_zero, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || quotient !== 32'd14) begin
            errors++;
            $display("FAIL divu done width: done=%b q=%0d want 0 14",
                     done, quotient);
        end
    endtask

    task automatic test_signed;
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'd1);
        run_div("divu 7/-2", 1'b0, 32'd7, 32'hFFFF_FFFE,
                32'd0, 32'd7);
    endtask

    task automatic test_boundary;
        run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1,
                32'hFFFF_FFFF, 32'd0);
        run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'd0);
        run_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001,
                32'd1, 32'h7FFF_FFFE);
    endtask

    task automatic test_div_zero;
        pulse_start(1'b0, 32'd1234, 32'd0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== 32'hFFFF_FFFF
            || remainder !== 32'd1234 || div_zero !== 1'b1) begin
            errors++;
            $display("FAIL divzero: done=%b busy=%b q=%h r=%0d dz=%b",
                     done, busy, quotient, remainder, div_zero);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b1) begin
            errors++;
            $display("FAIL divzero after: done=%b busy=%b dz=%b want 0 0 1",
                     done, busy, div_zero);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit ok;
        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        pulse_start(1'b0, 32'd50, 32'd5);
        n = 0;
        wait_done(n, ok);
        vectors++;
        if (!ok || n !== 24 || quotient !== 32'd14 || remainder !== 32'd2
            || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore busy start: n=%0d q=%0d r=%0d dz=%b want 24 14 2 0",
                     n, quotient, remainder, div_zero);
        end
        start     = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: done=%b busy=%b want 0 1", done, busy);
        end
        n = 0;
        wait_done(n, ok);
        vectors++;
        if (!ok || n !== 34 || quotient !== 32'd10 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL b2b result: n=%0d q=%0d r=%0d want 34 10 0",
                     n, quotient, remainder);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort;
        bit seen;
        pulse_start(1'b0, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd10
            || remainder !== 32'd0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b q=%0d r=%0d dz=%b want 0 0 10 0 0",
                     busy, done, quotient, remainder, div_zero);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || quotient !== 32'd10) begin
            errors++;
            $display("FAIL abort idle: activity=%b q=%0d want 0 10",
                     seen, quotient);
        end
    endtask

    task automatic test_reset_mid;
        run_div("pre rst", 1'b0, 32'd99, 32'd4, 32'd24, 32'd3);
        pulse_start(1'b0, 32'd1000, 32'd7);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, div_zero} !== 3'b000 || quotient !== 32'h0
            || remainder !== 32'h0) begin
            errors++;
            $display("FAIL async rst: busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 32'h0) begin
            errors++;
            $display("FAIL rst stays idle: done=%b busy=%b q=%h want 0 0 0",
                     done, busy, quotient);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_divu();
        test_signed();
        test_boundary();
        test_div_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
